// File: rtl/mdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdiv_seq
// Description : Sequential mixed-signedness integer divider. It produces a
//               truncating quotient and remainder using a restoring loop that
//               resolves one quotient bit per cycle. mode[0] marks opA as
//               signed and mode[1] marks opB as signed.
// Revision    : 1.0 - initial release
// ============================================================================
module mdiv_seq #(
  parameter int opAWidth = 8,
  parameter int opBWidth = 4,
  parameter int quoWidth = opAWidth + 1,
  parameter int remWidth = opBWidth + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [opAWidth-1:0] opA,
  input  logic [opBWidth-1:0] opB,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [quoWidth-1:0] quo,
  output logic [remWidth-1:0] rem,
  output logic                div_zero
);

  localparam int CNT_W = $clog2(opAWidth + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sa_q, sa_d;
  logic                  sb_q, sb_d;
  logic                  dz_q, dz_d;
  logic [opAWidth-1:0]   a_q, a_d;
  logic [opBWidth-1:0]   b_q, b_d;
  logic [opBWidth-1:0]   r_q, r_d;
  logic [opAWidth-1:0]   q_q, q_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [quoWidth-1:0]   quo_q, quo_d;
  logic [remWidth-1:0]   rem_q, rem_d;
  logic                  div_zero_q, div_zero_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept;
  logic                  in_sa, in_sb;
  logic [opAWidth-1:0]   mag_a;
  logic [opBWidth-1:0]   mag_b;
  logic [opBWidth:0]     rem_shift;
  logic [opBWidth+1:0]   trial;
  logic [quoWidth-1:0]   quo_mag, quo_signed;
  logic [remWidth-1:0]   rem_mag, rem_signed;

  // in_ready is gated by rst_n so that it reads low while reset is held
  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign div_zero  = div_zero_q;

  // Operand magnitudes, trial subtraction and sign fix-up of the final result
  always_comb begin
    in_sa      = mode[0] & opA[opAWidth-1];
    in_sb      = mode[1] & opB[opBWidth-1];
    // The most negative dividend maps to 2^(opAWidth-1), which still fits as unsigned
    mag_a      = in_sa ? (~opA + opAWidth'(1)) : opA;
    mag_b      = in_sb ? (~opB + opBWidth'(1)) : opB;
    rem_shift  = {r_q, a_q[opAWidth-1]};
    trial      = {1'b0, rem_shift} - {2'b00, b_q};
    quo_mag    = {1'b0, q_q};
    quo_signed = (sa_q ^ sb_q) ? (~quo_mag + quoWidth'(1)) : quo_mag;
    rem_mag    = {1'b0, r_q};
    rem_signed = sa_q ? (~rem_mag + remWidth'(1)) : rem_mag;
  end

  // Next-state and datapath updates for IDLE -> CALC -> DONE
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    dz_d        = dz_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sa_d    = in_sa;
          sb_d    = in_sb;
          a_d     = mag_a;
          b_d     = mag_b;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(opAWidth);
          dz_d    = (opB == '0);
          state_d = (opB == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        a_d = a_q << 1;
        // A clear sign bit in the trial means the divisor fits: keep the difference
        if (!trial[opBWidth+1]) begin
          r_d = trial[opBWidth-1:0];
          q_d = {q_q[opAWidth-2:0], 1'b1};
        end else begin
          r_d = rem_shift[opBWidth-1:0];
          q_d = {q_q[opAWidth-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The first DONE cycle registers the signed result; later cycles wait for the consumer
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          if (dz_q) begin
            quo_d      = '1;
            rem_d      = '0;
            div_zero_d = 1'b1;
          end else begin
            quo_d      = quo_signed;
            rem_d      = rem_signed;
            div_zero_d = 1'b0;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      dz_q        <= dz_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdiv_seq
// Description : Scoreboard bench for mdiv_seq using directed divisions with
//               hand-computed quotient and remainder values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdiv_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] opA;
  logic [3:0] opB;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] quo;
  logic [4:0] rem;
  logic       div_zero;

  typedef struct packed {
    logic [8:0] q;
    logic [4:0] r;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  mdiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got quo=%0h rem=%0h dz=%0b expected none", quo, rem, div_zero);
      end else begin
        e = exp_q.pop_front();
        chk("quo", 32'(quo), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.r));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
      end
    end
  end

  // Issue one division, check acceptance and latency; completes the handshake when out_ready=1
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic [1:0] m,
                         input logic [8:0] eq, input logic [4:0] er, input logic edz,
                         input int exp_lat);
    int lat;
    exp_q.push_back('{q: eq, r: er, dz: edz});
    @(negedge clk);
    opA = a; opB = b; mode = m; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk("out_valid_cleared", 32'(out_valid), 32'd0);
      chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; opA = '0; opB = '0; mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quo", 32'(quo), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: opA, opB, mode, quo, rem, div_zero, latency
    run_div(8'd200, 4'd7,  2'b00, 9'h01C, 5'h04, 1'b0, 9);
    run_div(8'h80,  4'hF,  2'b11, 9'h080, 5'h00, 1'b0, 9);
    run_div(8'hF9,  4'd2,  2'b01, 9'h1FD, 5'h1F, 1'b0, 9);
    run_div(8'hF9,  4'd2,  2'b00, 9'h07C, 5'h01, 1'b0, 9);
    run_div(8'd100, 4'h8,  2'b10, 9'h1F4, 5'h04, 1'b0, 9);
    run_div(8'd255, 4'hF,  2'b00, 9'h011, 5'h00, 1'b0, 9);
    run_div(8'h9C,  4'd3,  2'b11, 9'h1DF, 5'h1F, 1'b0, 9);
    run_div(8'd7,   4'd0,  2'b00, 9'h1FF, 5'h00, 1'b1, 1);

    // Divide by zero held against back-pressure, with an ignored request in the window
    out_ready = 1'b0;
    run_div(8'd50, 4'd0, 2'b11, 9'h1FF, 5'h00, 1'b1, 1);
    @(negedge clk);
    opA = 8'd200; opB = 4'd7; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_quo", 32'(quo), 32'h1FF);
      chk("hold_rem", 32'(rem), 32'h00);
      chk("hold_div_zero", 32'(div_zero), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 chk("hold_released", 32'(out_valid), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_request_no_result", 32'(out_valid), 32'd0);
    chk("ignored_request_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    opA = 8'd100; opB = 4'd3; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midcalc_rst_quo", 32'(quo), 32'd0);
    chk("midcalc_rst_rem", 32'(rem), 32'd0);
    chk("midcalc_rst_div_zero", 32'(div_zero), 32'd0);
    chk("midcalc_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_div(8'd200, 4'd7, 2'b00, 9'h01C, 5'h04, 1'b0, 9);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
